// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizing defaults and index type for the register file.
// Imported by reg_file and reg_file_read_port.
package reg_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_NUM_REGS   = 32;
    localparam int ZERO_REG_IDX       = 0;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file_read_port.sv
// reg_file_read_port: one combinational read port of the register file.
// Decodes addr_i against the stored entries 1..NumRegs-1 and masks index 0
// and out-of-range indices to zero. With REG_FILE_BYPASS_EN defined, a write
// in flight to the same index is forwarded to data_o before the edge.
// Ports:
//   regs_i      stored registers 1..NumRegs-1
//   addr_i      read index
//   wr_en_i     write enable of the write port
//   rst_n_i     active-low reset (blocks forwarding while asserted)
//   wr_addr_i   write index
//   wr_data_i   write data
//   data_o      read data
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int NumRegs    = DEFAULT_NUM_REGS,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic [DataWidth-1:0]  regs_i [NumRegs-1:1],
    input  logic [IndexWidth-1:0] addr_i,
    input  logic                  wr_en_i,
    input  logic                  rst_n_i,
    input  logic [IndexWidth-1:0] wr_addr_i,
    input  logic [DataWidth-1:0]  wr_data_i,
    output logic [DataWidth-1:0]  data_o
);

    localparam logic [IndexWidth:0] Limit = (IndexWidth + 1)'(NumRegs);

    logic                 hit;
    logic [DataWidth-1:0] stored;

    // Index 0 and indices past the last register never hit.
    assign hit = (addr_i != IndexWidth'(ZERO_REG_IDX)) &&
                 ({1'b0, addr_i} < Limit);

    always_comb begin
        stored = '0;
        for (int i = 1; i < NumRegs; i++) begin
            if (addr_i == IndexWidth'(i)) begin
                stored = regs_i[i];
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    always_comb begin
        data_o = '0;
        if (hit) begin
            data_o = stored;
            if (wr_en_i && rst_n_i && (wr_addr_i == addr_i)) begin
                data_o = wr_data_i;
            end
        end
    end
`else
    // Write-port signals only matter when forwarding is built in.
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, rst_n_i, wr_addr_i, wr_data_i};

    always_comb begin
        data_o = '0;
        if (hit) begin
            data_o = stored;
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// reg_file: general-purpose register file, one synchronous write port and
// two combinational read ports; register 0 reads as zero and is not stored.
// Optional write-through forwarding: define REG_FILE_BYPASS_EN.
// Ports:
//   clk         clock, state updates on rising edge
//   rst         synchronous active-low reset, wins over writeEn
//   writeEn     write enable
//   writeData   write data
//   writeAddr   write index (0 and out-of-range writes are dropped)
//   readAddr1/2 read indices
//   readData1/2 read data
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int NumRegs    = DEFAULT_NUM_REGS,
    parameter int IndexWidth = $clog2(NumRegs)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeEn,
    input  logic [DataWidth-1:0]  writeData,
    input  logic [IndexWidth-1:0] writeAddr,
    input  logic [IndexWidth-1:0] readAddr1,
    input  logic [IndexWidth-1:0] readAddr2,
    output logic [DataWidth-1:0]  readData1,
    output logic [DataWidth-1:0]  readData2
);

    logic [DataWidth-1:0] regs_q [NumRegs-1:1];
    logic [DataWidth-1:0] regs_d [NumRegs-1:1];

    // Only indices 1..NumRegs-1 have storage, so writes to 0 or past
    // the end simply match nothing.
    always_comb begin
        regs_d = regs_q;
        if (!rst) begin
            for (int i = 1; i < NumRegs; i++) begin
                regs_d[i] = '0;
            end
        end else if (writeEn) begin
            for (int i = 1; i < NumRegs; i++) begin
                if (writeAddr == IndexWidth'(i)) begin
                    regs_d[i] = writeData;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    reg_file_read_port #(
        .DataWidth  (DataWidth),
        .NumRegs    (NumRegs),
        .IndexWidth (IndexWidth)
    ) u_rd1 (
        .regs_i    (regs_q),
        .addr_i    (readAddr1),
        .wr_en_i   (writeEn),
        .rst_n_i   (rst),
        .wr_addr_i (writeAddr),
        .wr_data_i (writeData),
        .data_o    (readData1)
    );

    reg_file_read_port #(
        .DataWidth  (DataWidth),
        .NumRegs    (NumRegs),
        .IndexWidth (IndexWidth)
    ) u_rd2 (
        .regs_i    (regs_q),
        .addr_i    (readAddr2),
        .wr_en_i   (writeEn),
        .rst_n_i   (rst),
        .wr_addr_i (writeAddr),
        .wr_data_i (writeData),
        .data_o    (readData2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Expected values follow REG_FILE_BYPASS_EN when it is defined.
module tb_reg_file;
    import reg_file_pkg::*;

    localparam int DW = 64;
    localparam int NR = 32;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          rst;
    logic          writeEn;
    logic [DW-1:0] writeData;
    reg_idx_t      writeAddr;
    reg_idx_t      readAddr1;
    reg_idx_t      readAddr2;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file #(
        .DataWidth (DW),
        .NumRegs   (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .writeEn   (writeEn),
        .writeData (writeData),
        .writeAddr (writeAddr),
        .readAddr1 (readAddr1),
        .readAddr2 (readAddr2),
        .readData1 (readData1),
        .readData2 (readData2)
    );

    task automatic do_write(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        writeEn   = 1'b1;
        writeAddr = reg_idx_t'(a);
        writeData = d;
        @(posedge clk);
        #1;
        writeEn = 1'b0;
    endtask

    task automatic test_reset;
        do_write(4, 64'h0123_4567_89AB_CDEF);
        do_write(31, 64'h5555_AAAA_5555_AAAA);
        readAddr1 = reg_idx_t'(4);
        readAddr2 = reg_idx_t'(31);
        #1;
        checks++;
        if (readData1 !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL pre_reset r4 got=%h exp=%h",
                     readData1, 64'h0123_4567_89AB_CDEF);
        end
        checks++;
        if (readData2 !== 64'h5555_AAAA_5555_AAAA) begin
            failures++;
            $display("FAIL pre_reset r31 got=%h exp=%h",
                     readData2, 64'h5555_AAAA_5555_AAAA);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            readAddr1 = reg_idx_t'(i);
            readAddr2 = reg_idx_t'(i);
            #1;
            checks++;
            if (readData1 !== '0 || readData2 !== '0) begin
                failures++;
                $display("FAIL reset_clear a=%0d got1=%h got2=%h exp=0",
                         i, readData1, readData2);
            end
        end
    endtask

    task automatic test_fill;
        logic [DW-1:0] exp2;
        for (int i = 1; i < NR; i++) do_write(i, ONES);
        readAddr1 = reg_idx_t'(0);
        #1;
        checks++;
        if (readData1 !== '0) begin
            failures++;
            $display("FAIL fill_r0 got=%h exp=0", readData1);
        end
        for (int i = 1; i < NR; i++) begin
            readAddr1 = reg_idx_t'(i);
            readAddr2 = reg_idx_t'(i - 1);
            exp2 = (i == 1) ? '0 : ONES;
            #1;
            checks++;
            if (readData1 !== ONES || readData2 !== exp2) begin
                failures++;
                $display("FAIL fill a=%0d got1=%h got2=%h exp1=%h exp2=%h",
                         i, readData1, readData2, ONES, exp2);
            end
        end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        writeEn   = 1'b1;
        writeAddr = reg_idx_t'(0);
        writeData = 64'hDEAD_BEEF_0000_0001;
        readAddr1 = reg_idx_t'(0);
        #1;
        checks++;
        if (readData1 !== '0) begin
            failures++;
            $display("FAIL zero_pre got=%h exp=0", readData1);
        end
        @(posedge clk);
        #1;
        writeEn = 1'b0;
        checks++;
        if (readData1 !== '0) begin
            failures++;
            $display("FAIL zero_post got=%h exp=0", readData1);
        end
    endtask

    task automatic test_write_enable;
        @(negedge clk);
        writeEn   = 1'b0;
        writeAddr = reg_idx_t'(5);
        writeData = 64'h1234;
        readAddr1 = reg_idx_t'(5);
        @(posedge clk);
        #1;
        checks++;
        if (readData1 !== ONES) begin
            failures++;
            $display("FAIL we_gate got=%h exp=%h", readData1, ONES);
        end
    endtask

    task automatic test_reset_priority;
        @(negedge clk);
        rst       = 1'b0;
        writeEn   = 1'b1;
        writeAddr = reg_idx_t'(7);
        writeData = 64'hAA;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        writeEn = 1'b0;
        readAddr1 = reg_idx_t'(7);
        readAddr2 = reg_idx_t'(5);
        #1;
        checks++;
        if (readData1 !== '0) begin
            failures++;
            $display("FAIL rst_prio r7 got=%h exp=0", readData1);
        end
        checks++;
        if (readData2 !== '0) begin
            failures++;
            $display("FAIL rst_mid r5 got=%h exp=0", readData2);
        end
    endtask

    task automatic test_same_cycle;
        logic [DW-1:0] exp_pre;
`ifdef REG_FILE_BYPASS_EN
        exp_pre = 64'h2;
`else
        exp_pre = 64'h1;
`endif
        do_write(3, 64'h1);
        @(negedge clk);
        writeEn   = 1'b1;
        writeAddr = reg_idx_t'(3);
        writeData = 64'h2;
        readAddr1 = reg_idx_t'(3);
        readAddr2 = reg_idx_t'(4);
        #1;
        checks++;
        if (readData1 !== exp_pre) begin
            failures++;
            $display("FAIL same_pre got=%h exp=%h", readData1, exp_pre);
        end
        checks++;
        if (readData2 !== '0) begin
            failures++;
            $display("FAIL same_other got=%h exp=0", readData2);
        end
        @(posedge clk);
        #1;
        writeEn   = 1'b0;
        readAddr2 = reg_idx_t'(3);
        #1;
        checks++;
        if (readData1 !== 64'h2 || readData2 !== 64'h2) begin
            failures++;
            $display("FAIL same_post got1=%h got2=%h exp=2",
                     readData1, readData2);
        end
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] v;
        for (int i = 10; i < 16; i++) begin
            v = {32'hC0DE_0000 | 32'(i), 32'(i * 3)};
            do_write(i, v);
            readAddr1 = reg_idx_t'(i);
            readAddr2 = reg_idx_t'(i - 1);
            #1;
            checks++;
            if (readData1 !== v) begin
                failures++;
                $display("FAIL b2b a=%0d got=%h exp=%h", i, readData1, v);
            end
        end
        readAddr2 = reg_idx_t'(12);
        #1;
        checks++;
        if (readData2 !== {32'hC0DE_000C, 32'd36}) begin
            failures++;
            $display("FAIL b2b_keep got=%h exp=%h",
                     readData2, {32'hC0DE_000C, 32'd36});
        end
    endtask

    initial begin
        rst       = 1'b0;
        writeEn   = 1'b0;
        writeData = '0;
        writeAddr = '0;
        readAddr1 = '0;
        readAddr2 = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        test_reset();
        test_fill();
        test_zero_reg();
        test_write_enable();
        test_reset_priority();
        test_same_cycle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
